// File: rtl/config_ctrl.sv
// config_ctrl: decodes FIFO command words into FIR coefficient writes and the fir_open enable.
module config_ctrl #(
  parameter int DATA_W   = 4,
  parameter int COEF_W   = 4,
  parameter int NUM_TAPS = 2,
  parameter int ADDR_W   = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DATA_W-1:0]            in,
  input  logic                         empty,
  output logic                         rd_en,
  output logic [NUM_TAPS*COEF_W-1:0]   coef,
  output logic                         fir_open,
  output logic                         coef_upd,
  output logic [ADDR_W-1:0]            upd_addr,
  output logic                         addr_err,
  output logic                         busy
);
  typedef enum logic {IDLE, WAIT_DATA} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] pend_addr;
  logic [COEF_W-1:0] coef_r [NUM_TAPS];
  logic [1:0] op;
  logic wr, err, latch, open_d;
  assign op = in[DATA_W-1 -: 2];
  assign rd_en = ~empty;
  assign busy = state == WAIT_DATA;
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pack
    assign coef[k*COEF_W +: COEF_W] = coef_r[k];
  end
  always_comb begin
    state_d = state;
    wr = 1'b0;
    err = 1'b0;
    latch = 1'b0;
    open_d = fir_open;
    if (!empty && state == IDLE) begin
      latch = op == 2'b01;
      state_d = latch ? WAIT_DATA : IDLE;
      open_d = op == 2'b10 ? 1'b1 : op == 2'b00 ? fir_open : 1'b0;
    end else if (!empty) begin
      // the data word is never opcode-decoded, whatever its top bits hold
      state_d = IDLE;
      wr = int'(pend_addr) < NUM_TAPS;
      err = !wr;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      fir_open <= 1'b0;
      coef_upd <= 1'b0;
      addr_err <= 1'b0;
      upd_addr <= '0;
      pend_addr <= '0;
      for (int i = 0; i < NUM_TAPS; i++) coef_r[i] <= '0;
    end else begin
      state <= state_d;
      fir_open <= open_d;
      coef_upd <= wr;
      addr_err <= err;
      if (latch) pend_addr <= in[ADDR_W-1:0];
      if (wr) upd_addr <= pend_addr;
      for (int i = 0; i < NUM_TAPS; i++)
        if (wr && int'(pend_addr) == i) coef_r[i] <= in[COEF_W-1:0];
    end
  end
endmodule
